// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver: a sequential double-dabble converter feeds
// a display register, which is scanned digit by digit onto a shared segment bus.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int BIN_WIDTH     = 14,
  parameter int REFRESH_DIV   = 100000,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_WIDTH-1:0]  value,
  input  logic                  negative,
  input  logic                  blank_lz,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int ITER_W = $clog2(BIN_WIDTH + 1);

  localparam logic [6:0] GLYPH_MINUS = 7'b1111110;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // A negative value gives up the top digit to the minus sign.
  localparam logic [63:0] LIM_POS = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [63:0] LIM_NEG = pow10(NUM_DIGITS - 1) - 64'd1;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b0000001;
      4'd1:    glyph = 7'b1001111;
      4'd2:    glyph = 7'b0010010;
      4'd3:    glyph = 7'b0000110;
      4'd4:    glyph = 7'b1001100;
      4'd5:    glyph = 7'b0100100;
      4'd6:    glyph = 7'b0100000;
      4'd7:    glyph = 7'b0001111;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0000100;
      default: glyph = GLYPH_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t state;
  state_t state_next;

  // Handshake: load is a one-cycle request, taken only when busy=0; busy then stays
  // high until the converted value has been committed to the display register.
  logic accept;
  logic commit;

  logic [BIN_WIDTH-1:0] bin_q;
  logic [BCD_W-1:0]     bcd_q;
  logic [BCD_W-2:0]     bcd_adj;
  logic [ITER_W-1:0]    iter_q;
  logic                 cap_neg;
  logic                 cap_blz;
  logic                 cap_ovf;
  logic                 value_ovf;
  logic [63:0]          value_ext;

  logic [BCD_W-1:0] disp_bcd;
  logic             disp_neg;
  logic             disp_blz;
  logic             disp_ovf;

  logic [CNT_W-1:0]      refresh_cnt;
  logic [IDX_W-1:0]      scan_idx;
  logic [IDX_W-1:0]      msd;
  logic [IDX_W-1:0]      msd_up;
  logic [3:0]            cur_digit;
  logic [6:0]            glyph_cur;
  logic [NUM_DIGITS-1:0] onehot_cur;
  logic [NUM_DIGITS-1:0] an_cur;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = SHIFT;
      SHIFT:   if (iter_q == ITER_W'(BIN_WIDTH - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    commit = (state == COMMIT);
    accept = (state == IDLE) && load;
  end

  // ---------------- double-dabble datapath ----------------
  always_comb begin
    logic [3:0] nib;
    bcd_adj = '0;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      nib = bcd_q[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      bcd_adj[4*i +: 4] = nib;
    end
    // The top nibble's carry-out is shifted away, so only its low three bits survive.
    nib = bcd_q[BCD_W-1 -: 4];
    if (nib >= 4'd5) nib = nib + 4'd3;
    bcd_adj[BCD_W-2 -: 3] = nib[2:0];
  end

  always_comb begin
    value_ext = 64'(value);
    value_ovf = negative ? (value_ext > LIM_NEG) : (value_ext > LIM_POS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      cap_neg  <= 1'b0;
      cap_blz  <= 1'b1;
      cap_ovf  <= 1'b0;
      disp_bcd <= '0;
      disp_neg <= 1'b0;
      disp_blz <= 1'b1;
      disp_ovf <= 1'b0;
    end else begin
      if (accept) begin
        bin_q   <= value;
        bcd_q   <= '0;
        iter_q  <= '0;
        cap_neg <= negative;
        cap_blz <= blank_lz;
        cap_ovf <= value_ovf;
      end else if (state == SHIFT) begin
        bcd_q  <= {bcd_adj, bin_q[BIN_WIDTH-1]};
        bin_q  <= bin_q << 1;
        iter_q <= iter_q + 1'b1;
      end
      if (commit) begin
        disp_bcd <= bcd_q;
        disp_neg <= cap_neg;
        disp_blz <= cap_blz;
        disp_ovf <= cap_ovf;
      end
    end
  end

  assign overflow = disp_ovf;

  // ---------------- display composition ----------------
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (disp_bcd[4*i +: 4] != 4'd0) msd = IDX_W'(i);
    end
    msd_up    = msd + 1'b1;
    cur_digit = disp_bcd[4*scan_idx +: 4];
    if (disp_ovf) begin
      glyph_cur = GLYPH_MINUS;
    end else if (disp_blz) begin
      if (scan_idx <= msd)                      glyph_cur = glyph(cur_digit);
      else if (disp_neg && (scan_idx == msd_up)) glyph_cur = GLYPH_MINUS;
      else                                       glyph_cur = GLYPH_BLANK;
    end else if (disp_neg && (scan_idx == IDX_W'(NUM_DIGITS - 1))) begin
      glyph_cur = GLYPH_MINUS;
    end else begin
      glyph_cur = glyph(cur_digit);
    end
  end

  always_comb begin
    onehot_cur = NUM_DIGITS'(1) << scan_idx;
    an_cur     = AN_ACTIVE_LOW ? ~onehot_cur : onehot_cur;
  end

  // ---------------- scan timing ----------------
  // seg and an are registered together so segments never pair with the wrong enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
      seg         <= GLYPH_BLANK;
      an          <= AN_OFF;
    end else begin
      if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        scan_idx    <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      seg <= glyph_cur;
      an  <= an_cur;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: table of loads with expected glyphs per digit,
// plus hand sequences for reset scan order, load-while-busy and reset mid-conversion.
module tb_seven_seg_scan_driver;

  localparam int N  = 4;
  localparam int BW = 14;
  localparam int RD = 4;
  localparam bit AN_LOW = 1'b1;
  localparam int NV = 15;

  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010, G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100, G5 = 7'b0100100, G7 = 7'b0001111;
  localparam logic [6:0] G9 = 7'b0000100, GM = 7'b1111110, GB = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [BW-1:0] value;
  logic          negative;
  logic          blank_lz;
  logic          load;
  logic          busy;
  logic          overflow;
  logic [6:0]    seg;
  logic [N-1:0]  an;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS(N), .BIN_WIDTH(BW), .REFRESH_DIV(RD), .AN_ACTIVE_LOW(AN_LOW)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .negative(negative), .blank_lz(blank_lz),
    .load(load), .busy(busy), .overflow(overflow), .seg(seg), .an(an)
  );

  typedef struct {
    logic [BW-1:0]     value;
    logic              neg;
    logic              blz;
    logic              ovf;
    logic [N-1:0][6:0] g;   // g[3] is the leftmost digit
  } vec_t;

  vec_t vecs[NV];
  logic [N+6:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(input int v, input bit n, input bit b, input bit o,
                              input logic [N-1:0][6:0] g);
    vec_t r;
    r.value = BW'(v);
    r.neg   = n;
    r.blz   = b;
    r.ovf   = o;
    r.g     = g;
    return r;
  endfunction

  function automatic logic [N-1:0] an_on(input int d);
    logic [N-1:0] oh;
    oh    = '0;
    oh[d] = 1'b1;
    return oh ^ {N{AN_LOW}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Pulse load for one cycle and count the cycles busy stays high afterwards.
  task automatic run_load(input int v, input bit n, input bit b, output int busy_cycles);
    int cnt;
    @(negedge clk);
    value = BW'(v); negative = n; blank_lz = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cnt  = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    busy_cycles = cnt;
  endtask

  task automatic push_digits(input logic [N-1:0][6:0] g);
    for (int d = 0; d < N; d++) exp_q.push_back({an_on(d), g[d]});
  endtask

  // Watch two full scan periods, capture the glyph shown with each enable, compare.
  task automatic scan_display(input string name);
    logic [6:0]   got[N];
    logic [N+6:0] e;
    for (int d = 0; d < N; d++) got[d] = 7'bx;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 2 * N * RD; c++) begin
      for (int d = 0; d < N; d++) if (an == an_on(d)) got[d] = seg;
      @(negedge clk);
    end
    for (int d = 0; d < N; d++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check($sformatf("%s_d%0d", name, d), {an_on(d), got[d]}, e);
    end
  endtask

  initial begin
    int bc;
    vecs[0]  = mk(1234,  0, 0, 0, {G1, G2, G3, G4});
    vecs[1]  = mk(7,     1, 1, 0, {GB, GB, GM, G7});
    vecs[2]  = mk(42,    1, 0, 0, {GM, G0, G4, G2});
    vecs[3]  = mk(10000, 0, 0, 1, {GM, GM, GM, GM});
    vecs[4]  = mk(999,   1, 1, 0, {GM, G9, G9, G9});
    vecs[5]  = mk(1000,  1, 1, 1, {GM, GM, GM, GM});
    vecs[6]  = mk(0,     1, 1, 0, {GB, GB, GM, G0});
    vecs[7]  = mk(9999,  0, 1, 0, {G9, G9, G9, G9});
    vecs[8]  = mk(50,    0, 1, 0, {GB, GB, G5, G0});
    vecs[9]  = mk(305,   0, 0, 0, {G0, G3, G0, G5});
    vecs[10] = mk(305,   0, 1, 0, {GB, G3, G0, G5});
    vecs[11] = mk(0,     0, 0, 0, {G0, G0, G0, G0});
    vecs[12] = mk(16383, 0, 1, 1, {GM, GM, GM, GM});
    vecs[13] = mk(999,   1, 0, 0, {GM, G9, G9, G9});
    vecs[14] = mk(1,     1, 1, 0, {GB, GB, GM, G1});

    load = 1'b0; value = '0; negative = 1'b0; blank_lz = 1'b0;

    // Reset state and scan order after release
    #2 rst = 1'b1;
    #1;
    check("rst_seg", seg, GB);
    check("rst_an", an, {N{AN_LOW}});
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_seg_held", seg, GB);
    rst = 1'b0;
    for (int i = 0; i < 4 * RD; i++) exp_q.push_back({an_on(i / RD), (i / RD == 0) ? G0 : GB});
    for (int i = 0; i < 4 * RD; i++) begin
      @(negedge clk);
      check($sformatf("scan_seq_%0d", i), {an, seg}, exp_q.pop_front());
    end

    // Table-driven loads
    for (int k = 0; k < NV; k++) begin
      run_load(int'(vecs[k].value), vecs[k].neg, vecs[k].blz, bc);
      check($sformatf("busy_len_%0d", k), bc, BW + 1);
      check($sformatf("ovf_%0d", k), overflow, vecs[k].ovf);
      push_digits(vecs[k].g);
      scan_display($sformatf("vec%0d", k));
    end

    // Load while busy is ignored
    @(negedge clk);
    value = BW'(1234); negative = 1'b0; blank_lz = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bc   = 0;
    while (busy && bc < 100) begin
      bc++;
      if (bc == 3) begin value = BW'(5678); negative = 1'b1; load = 1'b1; end
      else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
    check("busy_ignore_len", bc, BW + 1);
    repeat (4) @(negedge clk);
    check("busy_ignore_idle", busy, 0);
    push_digits({G1, G2, G3, G4});
    scan_display("busy_ignore");

    // Reset in the middle of a conversion
    run_load(10000, 0, 0, bc);
    check("ovf_before_abort", overflow, 1);
    @(negedge clk);
    value = BW'(9999); negative = 1'b0; blank_lz = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_seg", seg, GB);
    check("abort_an", an, {N{AN_LOW}});
    check("abort_busy", busy, 0);
    check("abort_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_busy_after", busy, 0);
    check("abort_ovf_after", overflow, 0);
    push_digits({GB, GB, GB, G0});
    scan_display("abort_display");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
